// File: rtl/aes_loader_pkg.sv
// Shared definitions for the AES-128 byte loader: command codes, FSM states
// and the number of bytes per 128-bit word.
package aes_loader_pkg;

  localparam int NBYTES = 16;

  typedef enum logic [1:0] {
    GO  = 2'b00,
    KEY = 2'b01,
    PT  = 2'b10,
    CT  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    LAUNCH,
    WAIT
  } state_e;

endpackage

// File: rtl/aes_byte_loader_if.sv
// Byte-stream handshake into the AES loader: one byte plus command per beat,
// accepted when din_valid and din_ready are both high.
interface aes_byte_loader_if;

  logic [7:0] din;
  logic       din_valid;
  logic [1:0] cmd;
  logic       din_ready;

  modport master (output din, output din_valid, output cmd, input din_ready);
  modport slave  (input din, input din_valid, input cmd, output din_ready);

endinterface

// File: rtl/aes_byte_shifter.sv
// Staging shift register for one 128-bit word: bytes enter at the top so the
// first byte of a frame ends up in bits [7:0] once all bytes have arrived.
module aes_byte_shifter #(
  parameter int NBYTES = aes_loader_pkg::NBYTES
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic [7:0]            din,
  input  logic                  load_first,
  input  logic                  shift,
  output logic [8*NBYTES-1:0]   word_nxt,
  output logic                  last_byte
);

  localparam int SW = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES);

  logic [SW-1:0] stage_q, stage_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The lowest staged byte is always zero before a commit and is shifted out.
  logic unused_low_byte;
  assign unused_low_byte = &{1'b0, stage_q[7:0]};

  assign word_nxt  = {din, stage_q[SW-1:8]};
  assign last_byte = (cnt_q == CW'(NBYTES - 1));

  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (load_first) begin
      stage_d = {din, {(SW-8){1'b0}}};
      cnt_d   = CW'(1);
    end else if (shift) begin
      stage_d = word_nxt;
      cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/aes_byte_loader.sv
// Front-end for the AES-128 core: assembles key/plaintext/ciphertext words from
// a tagged byte stream, launches one encryption and waits for completion.
module aes_byte_loader #(
  parameter int NBYTES         = aes_loader_pkg::NBYTES,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_,
  aes_byte_loader_if.slave      bus,
  output logic [8*NBYTES-1:0]   input_key,
  output logic [8*NBYTES-1:0]   plain_text,
  output logic [8*NBYTES-1:0]   cipher_text,
  output logic                  start,
  input  logic                  cipher_ok,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  import aes_loader_pkg::*;

  localparam int SW = 8 * NBYTES;

  state_e          state_q, state_d;
  cmd_e            target_q, target_d;
  logic [SW-1:0]   key_q, key_d, pt_q, pt_d, ct_q, ct_d;
  logic            key_vld_q, key_vld_d, pt_vld_q, pt_vld_d, ct_vld_q, ct_vld_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            start_q, start_d, done_q, done_d, err_q, err_d;

  logic            accept;
  cmd_e            cmd;
  logic [SW-1:0]   word_nxt;
  logic            last_byte;

  // Nothing downstream consumes the ciphertext flag yet; it is kept for status.
  logic unused_ct_vld;
  assign unused_ct_vld = ct_vld_q;

  assign cmd           = cmd_e'(bus.cmd);
  assign bus.din_ready = (state_q == IDLE) || (state_q == LOAD);
  assign accept        = bus.din_valid && bus.din_ready;

  aes_byte_shifter #(.NBYTES(NBYTES)) u_shifter (
    .clk        (clk),
    .rst_       (rst_),
    .din        (bus.din),
    .load_first (accept && (state_q == IDLE) && (cmd != GO)),
    .shift      (accept && (state_q == LOAD)),
    .word_nxt   (word_nxt),
    .last_byte  (last_byte)
  );

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    key_d     = key_q;
    pt_d      = pt_q;
    ct_d      = ct_q;
    key_vld_d = key_vld_q;
    pt_vld_d  = pt_vld_q;
    ct_vld_d  = ct_vld_q;
    to_cnt_d  = to_cnt_q;
    start_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd == GO) begin
            if (key_vld_q && pt_vld_q) begin
              state_d = LAUNCH;
              start_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            target_d = cmd;
            state_d  = LOAD;
          end
        end
      end
      LOAD: begin
        // Commit only on the final byte so outputs never show a partial word.
        if (accept && last_byte) begin
          case (target_q)
            KEY: begin key_d = word_nxt; key_vld_d = 1'b1; end
            PT:  begin pt_d  = word_nxt; pt_vld_d  = 1'b1; end
            CT:  begin ct_d  = word_nxt; ct_vld_d  = 1'b1; end
            default: ;
          endcase
          state_d = IDLE;
        end
      end
      LAUNCH: begin
        to_cnt_d = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (cipher_ok) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= IDLE;
      target_q  <= KEY;
      key_q     <= '0;
      pt_q      <= '0;
      ct_q      <= '0;
      key_vld_q <= 1'b0;
      pt_vld_q  <= 1'b0;
      ct_vld_q  <= 1'b0;
      to_cnt_q  <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      key_q     <= key_d;
      pt_q      <= pt_d;
      ct_q      <= ct_d;
      key_vld_q <= key_vld_d;
      pt_vld_q  <= pt_vld_d;
      ct_vld_q  <= ct_vld_d;
      to_cnt_q  <= to_cnt_d;
      start_q   <= start_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign input_key   = key_q;
  assign plain_text  = pt_q;
  assign cipher_text = ct_q;
  assign start       = start_q;
  assign done        = done_q;
  assign err         = err_q;
  assign busy        = (state_q == LAUNCH) || (state_q == WAIT);

endmodule

// File: tb/tb_aes_byte_loader.sv
// Directed-plus-random bench for aes_byte_loader against a word-level model of
// the loaded key/plaintext/ciphertext and the launch/wait/timeout rules.
module tb_aes_byte_loader;

  import aes_loader_pkg::*;

  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst_;
  logic [127:0] input_key, plain_text, cipher_text;
  logic start, cipher_ok, busy, done, err;

  always #5 clk = ~clk;

  aes_byte_loader_if bus ();

  aes_byte_loader #(.NBYTES(16), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_        (rst_),
    .bus         (bus),
    .input_key   (input_key),
    .plain_text  (plain_text),
    .cipher_text (cipher_text),
    .start       (start),
    .cipher_ok   (cipher_ok),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: committed words and whether key/plaintext are armed.
  logic [127:0] m_key, m_pt, m_ct;
  bit           m_key_v, m_pt_v;

  logic [7:0]   fb[16];
  logic [127:0] lit;
  int           n;
  bit           seen;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pack(input logic [7:0] b[16]);
    logic [127:0] w = '0;
    for (int i = 0; i < 16; i++) w = w | (128'(b[i]) << (8 * i));
    return w;
  endfunction

  task automatic model_reset();
    m_key = '0; m_pt = '0; m_ct = '0;
    m_key_v = 1'b0; m_pt_v = 1'b0;
  endtask

  task automatic chk_words(input string tag);
    chk({tag, "_key"}, input_key, m_key);
    chk({tag, "_pt"}, plain_text, m_pt);
    chk({tag, "_ct"}, cipher_text, m_ct);
  endtask

  task automatic chk_idle(input string tag);
    chk_words(tag);
    chk({tag, "_start"}, start, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_ready"}, bus.din_ready, 1'b1);
  endtask

  // One frame with random idle gaps; cmd after the first beat is random noise.
  task automatic send_frame(input logic [1:0] c, input logic [7:0] b[16], input string tag);
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 2)) begin
        bus.din_valid = 1'b0;
        tick();
      end
      bus.din_valid = 1'b1;
      bus.cmd       = (i == 0) ? c : 2'($urandom);
      bus.din       = b[i];
      tick();
      if (i == 14) begin
        chk_words({tag, "_partial"});
        chk({tag, "_ready_mid"}, bus.din_ready, 1'b1);
      end
    end
    bus.din_valid = 1'b0;
    case (c)
      2'b01: begin m_key = pack(b); m_key_v = 1'b1; end
      2'b10: begin m_pt  = pack(b); m_pt_v  = 1'b1; end
      default: m_ct = pack(b);
    endcase
    chk_words({tag, "_commit"});
  endtask

  // Issues GO; ends one cycle after the response (in WAIT if launched).
  task automatic go_expect(input string tag, output bit launched);
    launched      = m_key_v && m_pt_v;
    bus.din_valid = 1'b1;
    bus.cmd       = 2'b00;
    bus.din       = 8'($urandom);
    tick();
    bus.din_valid = 1'b0;
    chk({tag, "_start"}, start, launched);
    chk({tag, "_err"}, err, !launched);
    chk({tag, "_busy"}, busy, launched);
    chk({tag, "_ready"}, bus.din_ready, !launched);
    tick();
    chk({tag, "_start_pulse"}, start, 1'b0);
    chk({tag, "_err_pulse"}, err, 1'b0);
    chk({tag, "_busy2"}, busy, launched);
  endtask

  // Stays in WAIT for lat cycles while offering beats that must be dropped.
  task automatic finish_run(input int lat, input string tag);
    for (int i = 0; i < lat; i++) begin
      bus.din_valid = 1'b1;
      bus.cmd       = 2'($urandom);
      bus.din       = 8'($urandom);
      tick();
      chk({tag, "_wait_ready"}, bus.din_ready, 1'b0);
      chk({tag, "_wait_busy"}, busy, 1'b1);
    end
    bus.din_valid = 1'b0;
    cipher_ok     = 1'b1;
    tick();
    cipher_ok = 1'b0;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_done_err"}, err, 1'b0);
    chk({tag, "_done_ready"}, bus.din_ready, 1'b1);
    chk({tag, "_done_busy"}, busy, 1'b0);
    tick();
    chk_idle({tag, "_after"});
  endtask

  initial begin
    bit l;
    rst_          = 1'b0;
    cipher_ok     = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    bus.cmd       = '0;
    model_reset();
    tick();
    tick();
    chk_idle("reset_hold");
    rst_ = 1'b1;
    tick();
    chk_idle("reset_idle");

    // Completion pulse outside WAIT is ignored.
    cipher_ok = 1'b1;
    tick();
    cipher_ok = 1'b0;
    chk("stray_ok_done", done, 1'b0);
    chk("stray_ok_busy", busy, 1'b0);

    go_expect("go_empty", l);

    for (int i = 0; i < 16; i++) fb[i] = 8'(15 - i);
    send_frame(2'b01, fb, "key_dir");
    chk("key_literal", input_key, 128'h000102030405060708090a0b0c0d0e0f);

    go_expect("go_no_pt", l);

    for (int i = 0; i < 16; i++) fb[i] = 8'(255 - i * 17);
    send_frame(2'b10, fb, "pt_dir");
    chk("pt_literal", plain_text, 128'h00112233445566778899aabbccddeeff);

    lit = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    for (int i = 0; i < 16; i++) fb[i] = lit[8*i +: 8];
    send_frame(2'b11, fb, "ct_dir");
    chk("ct_literal", cipher_text, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    go_expect("go_full", l);
    finish_run(10, "run_dir");

    // Random reloads of random targets followed by runs of random latency.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
      send_frame(2'($urandom_range(1, 3)), fb, "rnd_frame");
      go_expect("rnd_go", l);
      if (l) finish_run($urandom_range(0, 40), "rnd_run");
    end

    // Timeout with no completion, then a relaunch on the persisting words.
    go_expect("go_tmo", l);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 3 * TMO) begin
      tick();
      n++;
      if (err === 1'b1) seen = 1'b1;
    end
    chk("tmo_cycles", 128'(n), 128'(TMO));
    chk("tmo_done", done, 1'b0);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_ready", bus.din_ready, 1'b1);
    tick();
    chk_idle("tmo_after");
    go_expect("go_relaunch", l);
    finish_run(5, "relaunch");

    // Completion on the very cycle the timeout would fire: completion wins.
    go_expect("go_tie", l);
    repeat (TMO - 1) tick();
    chk("tie_busy", busy, 1'b1);
    cipher_ok = 1'b1;
    tick();
    cipher_ok = 1'b0;
    chk("tie_done", done, 1'b1);
    chk("tie_err", err, 1'b0);
    tick();
    chk_idle("tie_after");

    // Reset in the middle of a plaintext frame.
    for (int i = 0; i < 7; i++) begin
      bus.din_valid = 1'b1;
      bus.cmd       = (i == 0) ? 2'b10 : 2'($urandom);
      bus.din       = 8'($urandom);
      tick();
    end
    bus.din_valid = 1'b0;
    #2 rst_ = 1'b0;
    #1;
    model_reset();
    chk_idle("async_reset");
    @(negedge clk);
    rst_ = 1'b1;
    tick();
    chk_idle("post_reset");
    for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
    send_frame(2'b01, fb, "key_post");
    go_expect("go_post_nopt", l);
    for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
    send_frame(2'b10, fb, "pt_post");
    go_expect("go_post", l);
    chk("post_launched", 128'(l), 128'(1));
    finish_run(12, "run_post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
